// File: rtl/mat_elementwise_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mat_elementwise_seq_pkg : shared constants for the element-wise matrix   |
// | add/subtract block.                     Revision: 1.0                    |
// +--------------------------------------------------------------------------+
package mat_elementwise_seq_pkg;

    localparam int FLOAT_W  = 32;
    localparam int SIGN_BIT = 31;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int passes(input int m, input int n, input int lanes);
        return (m * n + lanes - 1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_elementwise_seq_fadd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mat_elementwise_seq_fadd : scalar IEEE-754 single adder, stb/ack ports,  |
// | round-to-nearest-even.                  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module mat_elementwise_seq_fadd
    import mat_elementwise_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] input_a,
    input  logic               input_a_stb,
    output logic               input_a_ack,
    input  logic [FLOAT_W-1:0] input_b,
    input  logic               input_b_stb,
    output logic               input_b_ack,
    output logic [FLOAT_W-1:0] output_z,
    output logic               output_z_stb,
    input  logic               output_z_ack
);

    localparam logic [1:0] F_RST  = 2'd0;
    localparam logic [1:0] F_GET  = 2'd1;
    localparam logic [1:0] F_CALC = 2'd2;
    localparam logic [1:0] F_OUT  = 2'd3;

    logic [1:0]         r_st;
    logic [FLOAT_W-1:0] r_a, r_b, r_z, w_sum;
    logic [FLOAT_W-1:0] w_big, w_small;
    logic [9:0]         w_eb, w_es, w_d, w_exp;
    logic [26:0]        w_sig_b, w_sig_s, w_sh_s, w_m;
    logic [27:0]        w_raw;
    logic [24:0]        w_rnd;
    logic               w_same, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    assign input_a_ack  = (r_st == F_GET);
    assign input_b_ack  = (r_st == F_GET);
    assign output_z_stb = (r_st == F_OUT);
    assign output_z     = r_z;

    always_comb begin
        w_a_nan = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
        w_b_nan = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
        w_a_inf = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
        w_b_inf = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
        w_big   = (r_b[30:0] > r_a[30:0]) ? r_b : r_a;
        w_small = (r_b[30:0] > r_a[30:0]) ? r_a : r_b;
        w_same  = (w_big[SIGN_BIT] == w_small[SIGN_BIT]);
        w_eb    = (w_big[30:23] == 8'd0) ? 10'd1 : {2'b00, w_big[30:23]};
        w_es    = (w_small[30:23] == 8'd0) ? 10'd1 : {2'b00, w_small[30:23]};
        w_sig_b = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
        w_sig_s = {(w_small[30:23] != 8'd0), w_small[22:0], 3'b000};
        w_d     = w_eb - w_es;
        // Alignment keeps a sticky bit so rounding sees every shifted-out one
        if (w_d >= 10'd27) begin
            w_sh_s = {26'd0, |w_sig_s};
        end else begin
            w_sh_s    = w_sig_s >> w_d;
            w_sh_s[0] = w_sh_s[0] | (|(w_sig_s & ((27'd1 << w_d) - 27'd1)));
        end
        w_raw = w_same ? ({1'b0, w_sig_b} + {1'b0, w_sh_s})
                       : ({1'b0, w_sig_b} - {1'b0, w_sh_s});
        w_exp = w_eb;
        if (w_raw[27]) begin
            w_m   = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_exp = w_eb + 10'd1;
        end else begin
            w_m = w_raw[26:0];
        end
        for (int i = 0; i < 26; i++) begin
            if (!w_m[26] && (w_exp > 10'd1)) begin
                w_m   = w_m << 1;
                w_exp = w_exp - 10'd1;
            end
        end
        w_rnd = {1'b0, w_m[26:3]} + {24'd0, w_m[2] & (w_m[1] | w_m[0] | w_m[3])};
        if (w_rnd[24]) begin
            w_rnd = w_rnd >> 1;
            w_exp = w_exp + 10'd1;
        end
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[SIGN_BIT] != r_b[SIGN_BIT]))) begin
            w_sum = 32'h7FC0_0000;
        end else if (w_a_inf) begin
            w_sum = r_a;
        end else if (w_b_inf) begin
            w_sum = r_b;
        end else if (w_raw == 28'd0) begin
            w_sum = {w_same & w_big[SIGN_BIT], 31'd0};
        end else if (w_exp >= 10'd255) begin
            w_sum = {w_big[SIGN_BIT], 8'hFF, 23'd0};
        end else begin
            w_sum = {w_big[SIGN_BIT], (w_rnd[23] ? w_exp[7:0] : 8'd0), w_rnd[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st <= F_RST;
            r_a  <= '0;
            r_b  <= '0;
            r_z  <= '0;
        end else begin
            case (r_st)
                F_RST:  r_st <= F_GET;
                F_GET: begin
                    if (input_a_stb && input_b_stb) begin
                        r_a  <= input_a;
                        r_b  <= input_b;
                        r_st <= F_CALC;
                    end
                end
                F_CALC: begin
                    r_z  <= w_sum;
                    r_st <= F_OUT;
                end
                F_OUT: begin
                    if (output_z_ack) r_st <= F_GET;
                end
                default: r_st <= F_RST;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mat_elementwise_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mat_elementwise_seq : time-multiplexed element-wise float matrix add/sub |
// | using LANES scalar adders swept over the matrix.  Revision: 1.0          |
// +--------------------------------------------------------------------------+
module mat_elementwise_seq
    import mat_elementwise_seq_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [M-1:0][N-1:0][FLOAT_W-1:0] input_a,
    input  logic [M-1:0][N-1:0][FLOAT_W-1:0] input_b,
    input  logic                           input_a_stb,
    input  logic                           input_b_stb,
    input  logic                           mode_sub,
    input  logic                           output_z_ack,
    output logic                           input_a_ack,
    output logic                           input_b_ack,
    output logic [M-1:0][N-1:0][FLOAT_W-1:0] output_z,
    output logic                           output_z_stb,
    output logic                           busy
);

    localparam int ELEMS  = M * N;
    localparam int PASSES = passes(M, N, LANES);
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int IW     = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    logic [1:0]                    r_state;
    logic [PW-1:0]                 r_pass;
    logic [ELEMS-1:0][FLOAT_W-1:0] r_a, r_b, r_z;
    logic                          r_sub, r_a_ack, r_b_ack, r_z_stb;
    logic [LANES-1:0]              r_acc, r_done;
    logic [LANES-1:0]              w_active, w_in_stb, w_a_ack, w_b_ack, w_take;
    logic [LANES-1:0]              w_z_ack, w_z_stb, w_zxfer;
    logic [LANES-1:0][FLOAT_W-1:0] w_lane_a, w_lane_b, w_lane_z;
    logic [LANES-1:0][IW-1:0]      w_idx;
    logic                          w_lane_rst, w_all_acc, w_all_done, w_last;

    assign w_lane_rst   = ~rst;
    assign input_a_ack  = r_a_ack;
    assign input_b_ack  = r_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_z_stb;
    assign busy         = (r_state != ST_IDLE);

    generate
        for (genvar gk = 0; gk < LANES; gk++) begin : g_lane
            logic [31:0] e_full;
            // Lanes past the last element in the tail pass stay idle
            assign e_full        = 32'(r_pass) * 32'(LANES) + 32'(gk);
            assign w_active[gk]  = (e_full < 32'(ELEMS));
            assign w_idx[gk]     = w_active[gk] ? e_full[IW-1:0] : '0;
            assign w_lane_a[gk]  = r_a[w_idx[gk]];
            assign w_lane_b[gk]  = r_b[w_idx[gk]] ^ {(r_sub == OP_SUB), {(FLOAT_W-1){1'b0}}};
            assign w_in_stb[gk]  = (r_state == ST_ISSUE) && w_active[gk] && !r_acc[gk];
            assign w_z_ack[gk]   = (r_state == ST_COLLECT) && w_active[gk] && !r_done[gk];

            mat_elementwise_seq_fadd u_fadd (
                .clk          (clk),
                .rst          (w_lane_rst),
                .input_a      (w_lane_a[gk]),
                .input_a_stb  (w_in_stb[gk]),
                .input_a_ack  (w_a_ack[gk]),
                .input_b      (w_lane_b[gk]),
                .input_b_stb  (w_in_stb[gk]),
                .input_b_ack  (w_b_ack[gk]),
                .output_z     (w_lane_z[gk]),
                .output_z_stb (w_z_stb[gk]),
                .output_z_ack (w_z_ack[gk])
            );
        end
    endgenerate

    assign w_take     = w_in_stb & w_a_ack & w_b_ack;
    assign w_zxfer    = w_z_ack & w_z_stb;
    assign w_all_acc  = &(r_acc | w_take | ~w_active);
    assign w_all_done = &(r_done | w_zxfer | ~w_active);
    assign w_last     = (r_pass == PW'(PASSES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pass  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_z     <= '0;
            r_sub   <= OP_ADD;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_z_stb <= 1'b0;
            r_acc   <= '0;
            r_done  <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (input_a_stb && input_b_stb) begin
                        r_a     <= input_a;
                        r_b     <= input_b;
                        r_sub   <= mode_sub;
                        r_a_ack <= 1'b1;
                        r_b_ack <= 1'b1;
                        r_pass  <= '0;
                        r_acc   <= '0;
                        r_done  <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_acc <= r_acc | w_take;
                    if (w_all_acc) begin
                        r_done  <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    r_done <= r_done | w_zxfer;
                    for (int k = 0; k < LANES; k++) begin
                        if (w_zxfer[k]) r_z[w_idx[k]] <= w_lane_z[k];
                    end
                    if (w_all_done) begin
                        r_acc  <= '0;
                        r_done <= '0;
                        if (w_last) begin
                            r_z_stb <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_pass  <= r_pass + 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (output_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mat_elementwise_seq.sv
`default_nettype none
// Bench for mat_elementwise_seq: two 2x2 instances (4 lanes, 3 lanes) share stimulus;
// results are checked against a real-arithmetic float model and hand-computed literals.
module tb_mat_elementwise_seq;

    typedef logic [1:0][1:0][31:0] mat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mat_t input_a = '0;
    mat_t input_b = '0;
    logic a_stb = 1'b0, b_stb = 1'b0, mode_sub = 1'b0, z_ack = 1'b0;

    mat_t z3, z4;
    logic a_ack3, b_ack3, zstb3, busy3;
    logic a_ack4, b_ack4, zstb4, busy4;

    int   checks = 0;
    int   errors = 0;
    mat_t exp_z = '0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    mat_elementwise_seq #(.M(2), .N(2), .LANES(3)) dut3 (
        .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
        .input_a_stb(a_stb), .input_b_stb(b_stb), .mode_sub(mode_sub),
        .output_z_ack(z_ack), .input_a_ack(a_ack3), .input_b_ack(b_ack3),
        .output_z(z3), .output_z_stb(zstb3), .busy(busy3)
    );

    mat_elementwise_seq #(.M(2), .N(2), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
        .input_a_stb(a_stb), .input_b_stb(b_stb), .mode_sub(mode_sub),
        .output_z_ack(z_ack), .input_a_ack(a_ack4), .input_b_ack(b_ack4),
        .output_z(z4), .output_z_stb(zstb4), .busy(busy4)
    );

    function automatic logic [31:0] el(input mat_t m, input int e);
        return m[e/2][e%2];
    endfunction

    function automatic mat_t mk(input logic [31:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        real v;
        if (f[30:23] == 8'd0) v = real'(f[22:0]) * pow2(-149);
        else v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        real  v;
        int   e;
        int   mant;
        logic s;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        mant = $rtoi((v - 1.0) * 8388608.0);
        return {s, 8'(e + 127), 23'(mant)};
    endfunction

    function automatic logic [31:0] model_elem(input logic [31:0] a, b, input logic sub);
        real r;
        r = sub ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        return r2f(r);
    endfunction

    function automatic mat_t model(input mat_t a, b, input logic sub);
        mat_t m;
        for (int e = 0; e < 4; e++) m[e/2][e%2] = model_elem(el(a, e), el(b, e), sub);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %08h, want %08h", name, act, want);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, act, want);
        end
    endtask

    // Per-cycle checker: captures define the model's expectation, valid Z must match it
    always @(negedge clk) begin
        if (rst) begin
            if (a_ack3 | b_ack3 | a_ack4 | b_ack4) begin
                chk1("ack_a3", a_ack3, 1'b1);
                chk1("ack_b3", b_ack3, 1'b1);
                chk1("ack_a4", a_ack4, 1'b1);
                chk1("ack_b4", b_ack4, 1'b1);
                chk1("ack_needs_both_stb", a_stb & b_stb, 1'b1);
                chk1("ack_single_pulse", prev_ack, 1'b0);
                exp_z = model(input_a, input_b, mode_sub);
            end
            prev_ack = a_ack3 | a_ack4;
            if (zstb3) begin
                for (int e = 0; e < 4; e++) chk("model_z3", el(z3, e), el(exp_z, e));
                chk1("busy3_in_done", busy3, 1'b1);
            end
            if (zstb4) begin
                for (int e = 0; e < 4; e++) chk("model_z4", el(z4, e), el(exp_z, e));
                chk1("busy4_in_done", busy4, 1'b1);
            end
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_ack3 | a_ack4) && n < 20);
        chk1("input_ack_seen", a_ack3 | a_ack4, 1'b1);
        @(posedge clk); #1;
        a_stb = 1'b0;
        b_stb = 1'b0;
        input_a = ~input_a;
        input_b = ~input_b;
        mode_sub = ~mode_sub;
    endtask

    task automatic issue(input mat_t a, input mat_t b, input logic sub, input int skew);
        @(posedge clk); #1;
        input_a = a;
        input_b = b;
        mode_sub = sub;
        a_stb = 1'b1;
        if (skew > 0) begin
            repeat (skew) begin
                @(negedge clk);
                chk1("skew_no_ack", a_ack3 | b_ack3 | a_ack4 | b_ack4, 1'b0);
            end
            @(posedge clk); #1;
        end
        b_stb = 1'b1;
        wait_ack();
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(zstb3 && zstb4) && n < 100);
        chk1("done3_seen", zstb3, 1'b1);
        chk1("done4_seen", zstb4, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk1("zstb3_held", zstb3, 1'b1);
            chk1("zstb4_held", zstb4, 1'b1);
        end
    endtask

    task automatic check_lit(input mat_t ez);
        for (int e = 0; e < 4; e++) begin
            chk("lit_z3", el(z3, e), el(ez, e));
            chk("lit_z4", el(z4, e), el(ez, e));
        end
    endtask

    task automatic ack_z();
        @(posedge clk); #1;
        z_ack = 1'b1;
        @(posedge clk); #1;
        z_ack = 1'b0;
        @(negedge clk);
        chk1("zstb3_dropped", zstb3, 1'b0);
        chk1("zstb4_dropped", zstb4, 1'b0);
        chk1("busy3_idle", busy3, 1'b0);
        chk1("busy4_idle", busy4, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_zstb3"}, zstb3, 1'b0);
        chk1({tag, "_zstb4"}, zstb4, 1'b0);
        chk1({tag, "_busy3"}, busy3, 1'b0);
        chk1({tag, "_busy4"}, busy4, 1'b0);
        chk1({tag, "_acks"}, a_ack3 | b_ack3 | a_ack4 | b_ack4, 1'b0);
        for (int e = 0; e < 4; e++) begin
            chk({tag, "_z3"}, el(z3, e), 32'h0);
            chk({tag, "_z4"}, el(z4, e), 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        chk("model_pin_sub", model_elem(32'h40400000, 32'hBF800000, 1'b1), 32'h40800000);
        chk("model_pin_add", model_elem(32'h3FC00000, 32'h3F000000, 1'b0), 32'h40000000);

        // 1.0 + 2.0 everywhere
        issue(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000),
              mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), 1'b0, 0);
        wait_done();
        check_lit(mk(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000));
        ack_z();

        // 3.0 - {1, 2, 3, -1}: tail pass on the 3-lane instance
        issue(mk(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000),
              mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000), 1'b1, 0);
        wait_done();
        check_lit(mk(32'h40000000, 32'h3F800000, 32'h00000000, 32'h40800000));
        ack_z();

        // A strobe leads B by five cycles
        issue(mk(32'h3F000000, 32'h3FC00000, 32'hC0000000, 32'h40800000),
              mk(32'h3E800000, 32'h3F000000, 32'h3F800000, 32'hC0800000), 1'b0, 5);
        wait_done();
        check_lit(mk(32'h3F400000, 32'h40000000, 32'hBF800000, 32'h00000000));
        ack_z();

        // Back-pressure: Z held 20 cycles with a new request pending
        issue(mk(32'h41200000, 32'h3F800000, 32'hBF800000, 32'h40A00000),
              mk(32'h40000000, 32'h3F800000, 32'hBF800000, 32'h3F000000), 1'b1, 0);
        wait_done();
        check_lit(mk(32'h41000000, 32'h00000000, 32'h00000000, 32'h40900000));
        @(posedge clk); #1;
        input_a = mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        input_b = mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        mode_sub = 1'b0;
        a_stb = 1'b1;
        b_stb = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk1("bp_no_input_ack", a_ack3 | b_ack3 | a_ack4 | b_ack4, 1'b0);
            chk1("bp_zstb_held", zstb3 & zstb4, 1'b1);
        end
        check_lit(mk(32'h41000000, 32'h00000000, 32'h00000000, 32'h40900000));
        ack_z();
        wait_ack();
        wait_done();
        check_lit(mk(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000));
        ack_z();

        // Reset in the middle of the 3-lane instance's second pass
        issue(mk(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000),
              mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000), 1'b1, 0);
        repeat (4) @(negedge clk);
        chk1("busy3_mid_op", busy3, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_state("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        issue(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000),
              mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000), 1'b0, 0);
        wait_done();
        check_lit(mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000));
        ack_z();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat_elementwise_seq.md
Name: mat_elementwise_seq

Overview:
- Parametrised, time-multiplexed element-wise matrix add/subtract on IEEE-754 single-precision M x N matrices.
- Successor to the fully parallel matrix-sum block. It instantiates LANES scalar float adders instead of M*N and sweeps the matrix in passes.
- Adds a per-transaction subtract mode and operand capture registers.
- Sits between layer-datapath producers (bias add, residual add, gradient update) and downstream consumers, using the codebase stb/ack handshake on every side.

Parameters:
- M, 4, matrix rows (>=1)
- N, 4, matrix columns (>=1)
- LANES, 4, parallel scalar adders (1..M*N)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- input_a  in  [M-1:0][N-1:0][31:0]  operand matrix A
- input_b  in  [M-1:0][N-1:0][31:0]  operand matrix B
- input_a_stb  in  1  A valid
- input_b_stb  in  1  B valid
- mode_sub  in  1  0: Z=A+B; 1: Z=A-B; sampled with operands
- output_z_ack  in  1  consumer accepted Z
- input_a_ack  out  1  A captured (1-cycle pulse)
- input_b_ack  out  1  B captured (1-cycle pulse)
- output_z  out  [M-1:0][N-1:0][31:0]  result matrix, registered
- output_z_stb  out  1  Z valid, held until acked
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, pass counter=0, all acks/stb/busy=0, output_z=0, lane handshakes idle.
- Lane adders are reset with the inverted rst, because the scalar adder has an active-high reset.
- Element index e = i*N + j. Pass p covers e in [p*LANES, p*LANES+LANES-1]. PASSES = ceil(M*N/LANES).
- IDLE:
  - When input_a_stb && input_b_stb are both high on the same edge: capture A, B and mode_sub into internal registers.
  - Pulse input_a_ack and input_b_ack high for exactly that cycle, then go to ISSUE with p=0.
  - Only one stb high: no capture and no ack; wait.
- ISSUE:
  - Drive lane k with A[e], and with B[e] or B[e] with bit 31 inverted when mode_sub=1.
  - Assert stb to all lanes. As each lane acks, drop that lane's stbs; track per-lane "accepted" flags.
  - When all active lanes have accepted, go to COLLECT.
- COLLECT:
  - As each lane raises output_z_stb, store its result into output_z[e] and pulse that lane's output_z_ack.
  - When all active lanes have completed: if p == PASSES-1, go to DONE; otherwise p++ and go to ISSUE.
- Tail pass (M*N not a multiple of LANES):
  - Unused lanes are held idle (stb=0) and excluded from the all-accepted/all-done reductions.
  - No writes outside the matrix.
- DONE:
  - output_z_stb=1; output_z stable.
  - On output_z_ack=1: drop output_z_stb next cycle and return to IDLE. The next transaction may be captured starting the cycle after.
  - Capture-while-DONE is not permitted: input acks stay low until IDLE.
- Throughput/latency:
  - Capture cycle + PASSES * (lane issue + adder latency + collect) + 1 cycle to DONE.
  - With LANES = M*N there is exactly one pass.
- output_z holds the last result after DONE until it is overwritten element-by-element by the next transaction.
- Sign-bit flip is exact for all encodings, including zero, inf and NaN. No other arithmetic is done in this block.
- mode_sub and input_a/input_b changes after capture have no effect on the in-flight transaction.

Decomposition:
- Shared linalg package holds:
  - FLOAT_W=32 and SIGN_BIT=31
  - state enum {IDLE, ISSUE, COLLECT, DONE}
  - passes function ceil(M*N/LANES)
  - 1-bit op-mode constants OP_ADD/OP_SUB
- One natural sub-module: the existing scalar float adder, instantiated LANES times in a generate loop.
- Lane operand muxing and sign flip stay inline.

Test Plan:
- M=N=2, LANES=4, mode_sub=0:
  - Stimulus: A all 0x3F800000 (1.0), B all 0x40000000 (2.0).
  - Response: single pass; output_z all 0x40400000 (3.0); output_z_stb held until ack; acks pulse once.
- M=N=2, LANES=3, mode_sub=1:
  - Stimulus: A = {3.0,3.0,3.0,3.0}, B = {1.0,2.0,3.0,-1.0 (0xBF800000)}.
  - Response: 2 passes; Z = {0x40000000, 0x3F800000, 0x00000000, 0x40800000}; lanes 1-2 idle in tail pass.
- Handshake skew:
  - Stimulus: input_a_stb high 5 cycles before input_b_stb.
  - Response: no ack until both are high; both acks pulse on the same cycle.
- Back-pressure:
  - Stimulus: hold output_z_ack=0 for 20 cycles in DONE while new stbs are asserted.
  - Response: output_z stable, no input acks; after ack, the next transaction is captured and Z is correct.
- Reset mid-operation:
  - Stimulus: drop rst in COLLECT of pass 1.
  - Response: outputs zero immediately; busy=0. After release, a fresh 1.0+1.0 transaction yields all 0x40000000.
